// File: rtl/bridge_tx_arb_if.sv
// Requester/transmit-channel bundle for bridge_tx_arb: requester words and strobes,
// the tx launch/sent handshake, and arbiter status.
interface bridge_tx_arb_if #(
  parameter int DATA_W = 32,
  parameter int N_REQ  = 4,
  parameter int PTR_W  = 3
);
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_done;
  logic [DATA_W-1:0]       sdata;
  logic                    vi;
  logic                    snt;
  logic                    busy;
  logic [PTR_W-1:0]        grant_id;
  logic [15:0]             xfer_cnt;

  modport slave (
    input  req_valid, req_data, snt,
    output req_done, sdata, vi, busy, grant_id, xfer_cnt
  );

  modport master (
    output req_valid, req_data, snt,
    input  req_done, sdata, vi, busy, grant_id, xfer_cnt
  );
endinterface

// File: rtl/bridge_tx_arb.sv
// Round-robin arbiter sequencing one tx transfer at a time (grant, vi launch, wait snt, done).
// Optional BRIDGE_ARB_PRIO0_EN: requester 0 always wins in IDLE and does not move the pointer.
module bridge_tx_arb #(
  parameter int DATA_W = 32,
  parameter int N_REQ  = 4,
  parameter int PTR_W  = 3
) (
  input  logic           clk,
  input  logic           reset,
  bridge_tx_arb_if.slave bus
);
  localparam int CW = PTR_W + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_t;

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [PTR_W-1:0]  grant_q, grant_d;
  logic [DATA_W-1:0] sdata_q, sdata_d;
  logic              vi_q;
  logic              busy_q;
  logic [N_REQ-1:0]  req_done_q;
  logic [15:0]       xfer_cnt_q;

  logic [PTR_W-1:0]  cand [N_REQ];
  logic [N_REQ-1:0]  rot_valid;
  logic              any_req;
  logic [PTR_W-1:0]  sel_idx;
  logic [DATA_W-1:0] sel_word;

  // cand[gi] is the requester index at offset gi from ptr, wrapped without power-of-two math
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
      logic [CW-1:0] sum;
      assign sum          = {1'b0, ptr_q} + CW'(gi);
      assign cand[gi]     = (sum >= CW'(N_REQ)) ? PTR_W'(sum - CW'(N_REQ)) : PTR_W'(sum);
      assign rot_valid[gi] = |(bus.req_valid & (N_REQ'(1) << cand[gi]));
    end
  endgenerate

  always_comb begin
    any_req = 1'b0;
    sel_idx = '0;
    // Descending scan so the smallest offset from ptr is the one left standing
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot_valid[k]) begin
        any_req = 1'b1;
        sel_idx = cand[k];
      end
    end
`ifdef BRIDGE_ARB_PRIO0_EN
    if (bus.req_valid[0]) begin
      sel_idx = '0;
    end
`endif
  end

  always_comb begin
    sel_word = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (sel_idx == PTR_W'(k)) begin
        sel_word = bus.req_data[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    sdata_d = sdata_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          grant_d = sel_idx;
          sdata_d = sel_word;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (bus.snt) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        ptr_d   = (grant_q == PTR_W'(N_REQ - 1)) ? '0 : grant_q + PTR_W'(1);
`ifdef BRIDGE_ARB_PRIO0_EN
        if (grant_q == '0) begin
          ptr_d = ptr_q;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      grant_q    <= '0;
      sdata_q    <= '0;
      vi_q       <= 1'b0;
      busy_q     <= 1'b0;
      req_done_q <= '0;
      xfer_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      sdata_q    <= sdata_d;
      // Strobes are decoded from the next state so they line up with the state they belong to
      vi_q       <= (state_d == ST_ISSUE);
      busy_q     <= (state_d != ST_IDLE);
      req_done_q <= (state_d == ST_DONE) ? (N_REQ'(1) << grant_d) : '0;
      if (state_q == ST_DONE) begin
        xfer_cnt_q <= xfer_cnt_q + 16'd1;
      end
    end
  end

  assign bus.sdata    = sdata_q;
  assign bus.vi       = vi_q;
  assign bus.busy     = busy_q;
  assign bus.req_done = req_done_q;
  assign bus.grant_id = grant_q;
  assign bus.xfer_cnt = xfer_cnt_q;
endmodule

// File: tb/tb_bridge_tx_arb.sv
// Bench for bridge_tx_arb: directed table of arbitration vectors, hand-written corner
// sequences, and randomized transfers checked against a round-robin reference model.
`timescale 1ns/1ps
module tb_bridge_tx_arb;
  localparam int DATA_W = 32;
  localparam int N_REQ  = 4;
  localparam int PTR_W  = 3;

  logic clk = 1'b0;
  logic reset;

  bridge_tx_arb_if #(.DATA_W(DATA_W), .N_REQ(N_REQ), .PTR_W(PTR_W)) bus ();

  bridge_tx_arb #(.DATA_W(DATA_W), .N_REQ(N_REQ), .PTR_W(PTR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          m_ptr;
  int unsigned m_cnt;
  int          n_xfer = 0;
  logic [DATA_W-1:0] words [N_REQ];

  typedef struct {
    logic [N_REQ-1:0] mask;
    int               delay;
    int               exp_grant;
  } vec_t;
  vec_t vecs [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pack_words();
    for (int i = 0; i < N_REQ; i++) bus.req_data[i*DATA_W +: DATA_W] = words[i];
  endtask

  task automatic rand_words();
    for (int i = 0; i < N_REQ; i++) words[i] = $urandom;
    pack_words();
  endtask

  // Reference: first requesting index at or above ptr, wrapping modulo N_REQ
  function automatic int model_grant(input logic [N_REQ-1:0] mask);
`ifdef BRIDGE_ARB_PRIO0_EN
    if (mask[0]) return 0;
`endif
    for (int off = 0; off < N_REQ; off++) begin
      int idx;
      idx = (m_ptr + off) % N_REQ;
      if (mask[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic bit ptr_moves(input int g);
`ifdef BRIDGE_ARB_PRIO0_EN
    return g != 0;
`else
    return g >= 0;
`endif
  endfunction

  task automatic model_done(input int g);
    if (ptr_moves(g)) m_ptr = (g + 1) % N_REQ;
    m_cnt++;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    bus.req_valid = '0;
    bus.snt = 1'b0;
    step();
    step();
    reset = 1'b0;
    m_ptr = 0;
    m_cnt = 0;
  endtask

  // One full transfer; mask is sampled in the current IDLE cycle, snt returned delay cycles into WAIT
  task automatic run_xfer(input logic [N_REQ-1:0] mask, input int delay, input int exp_g, input bit drop);
    logic [N_REQ-1:0] done_exp;
    done_exp = N_REQ'(1) << exp_g;
    bus.req_valid = mask;
    step();
    check("vi_issue", bus.vi, 1);
    check("busy_issue", bus.busy, 1);
    check("grant_id", bus.grant_id, exp_g);
    check("sdata_issue", bus.sdata, words[exp_g]);
    bus.req_data = ~bus.req_data;
    if (drop) bus.req_valid = '0;
    step();
    check("vi_wait", bus.vi, 0);
    for (int d = 0; d < delay; d++) begin
      check("done_early", bus.req_done, 0);
      check("sdata_wait", bus.sdata, words[exp_g]);
      step();
    end
    bus.snt = 1'b1;
    step();
    bus.snt = 1'b0;
    check("req_done", bus.req_done, done_exp);
    check("sdata_done", bus.sdata, words[exp_g]);
    bus.req_valid = bus.req_valid & ~done_exp;
    model_done(exp_g);
    step();
    check("done_clear", bus.req_done, 0);
    check("busy_idle", bus.busy, 0);
    check("xfer_cnt", bus.xfer_cnt, 64'(m_cnt[15:0]));
    n_xfer++;
    $display("xfer %0d: mask=%b grant=%0d sdata=%h delay=%0d drop=%0d cnt=%0d",
             n_xfer, mask, exp_g, words[exp_g], delay, drop, bus.xfer_cnt);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.req_data = '0;
    reset_dut();
    check("rst_vi", bus.vi, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_req_done", bus.req_done, 0);
    check("rst_grant_id", bus.grant_id, 0);
    check("rst_sdata", bus.sdata, 0);
    check("rst_xfer_cnt", bus.xfer_cnt, 0);

    // Single request: snt in cycle 7, done in cycle 8
    rand_words();
    words[2] = 32'hDEADBEEF;
    pack_words();
    run_xfer(4'b0100, 5, 2, 1'b0);

    // Table of arbitration vectors from a fresh pointer
    reset_dut();
`ifdef BRIDGE_ARB_PRIO0_EN
    vecs[0] = '{4'b1111, 0, 0};
    vecs[1] = '{4'b1111, 1, 0};
    vecs[2] = '{4'b1111, 3, 0};
    vecs[3] = '{4'b1110, 0, 1};
    vecs[4] = '{4'b1110, 2, 2};
    vecs[5] = '{4'b0001, 0, 0};
    vecs[6] = '{4'b1010, 0, 3};
    vecs[7] = '{4'b1010, 1, 1};
    vecs[8] = '{4'b1011, 0, 0};
    vecs[9] = '{4'b0010, 0, 1};
`else
    vecs[0] = '{4'b1111, 0, 0};
    vecs[1] = '{4'b1111, 1, 1};
    vecs[2] = '{4'b1111, 3, 2};
    vecs[3] = '{4'b1111, 0, 3};
    vecs[4] = '{4'b1111, 2, 0};
    vecs[5] = '{4'b0001, 0, 0};
    vecs[6] = '{4'b1000, 0, 3};
    vecs[7] = '{4'b0110, 1, 1};
    vecs[8] = '{4'b0110, 0, 2};
    vecs[9] = '{4'b0011, 0, 0};
`endif
    for (int i = 0; i < 10; i++) begin
      rand_words();
      run_xfer(vecs[i].mask, vecs[i].delay, vecs[i].exp_grant, 1'b0);
    end
    bus.req_valid = '0;

    // Spurious snt in IDLE, then in ISSUE
    step();
    bus.snt = 1'b1;
    step();
    bus.snt = 1'b0;
    check("spur_idle_busy", bus.busy, 0);
    check("spur_idle_done", bus.req_done, 0);
    check("spur_idle_cnt", bus.xfer_cnt, 64'(m_cnt[15:0]));
    begin
      int g;
      rand_words();
      g = model_grant(4'b0001);
      bus.req_valid = 4'b0001;
      step();
      bus.snt = 1'b1;
      step();
      bus.snt = 1'b0;
      check("spur_issue_busy", bus.busy, 1);
      check("spur_issue_done", bus.req_done, 0);
      step();
      check("spur_wait_hold", bus.busy, 1);
      check("spur_wait_done", bus.req_done, 0);
      bus.snt = 1'b1;
      step();
      bus.snt = 1'b0;
      check("spur_real_done", bus.req_done, 4'b0001 << g);
      bus.req_valid = '0;
      model_done(g);
      step();
      check("spur_cnt", bus.xfer_cnt, 64'(m_cnt[15:0]));
    end

    // Requester drops req_valid while in WAIT
    rand_words();
    run_xfer(4'b0010, 2, model_grant(4'b0010), 1'b1);

    // Reset pulse while in WAIT aborts the transfer
    rand_words();
    bus.req_valid = 4'b1000;
    step();
    step();
    step();
    reset = 1'b1;
    bus.req_valid = '0;
    step();
    reset = 1'b0;
    m_ptr = 0;
    m_cnt = 0;
    check("wrst_vi", bus.vi, 0);
    check("wrst_busy", bus.busy, 0);
    check("wrst_done", bus.req_done, 0);
    check("wrst_grant", bus.grant_id, 0);
    check("wrst_sdata", bus.sdata, 0);
    check("wrst_cnt", bus.xfer_cnt, 0);
    bus.snt = 1'b1;
    step();
    bus.snt = 1'b0;
    check("late_snt_done", bus.req_done, 0);
    check("late_snt_busy", bus.busy, 0);
    step();
    check("late_snt_done2", bus.req_done, 0);
    check("late_snt_cnt", bus.xfer_cnt, 0);

    // Counter wrap: preload 65535 completed transfers, then one more
    force dut.xfer_cnt_q = 16'hFFFF;
    step();
    release dut.xfer_cnt_q;
    step();
    check("cnt_preload", bus.xfer_cnt, 16'hFFFF);
    m_cnt = 32'd65535;
    rand_words();
    run_xfer(4'b0100, 1, model_grant(4'b0100), 1'b0);
    check("cnt_wrap", bus.xfer_cnt, 16'h0000);

    // Randomized transfers against the reference model
    reset_dut();
    for (int t = 0; t < 120; t++) begin
      logic [N_REQ-1:0] mask;
      int gap;
      bus.req_valid = '0;
      gap = $urandom_range(0, 2);
      for (int c = 0; c < gap; c++) begin
        bus.snt = ($urandom_range(0, 1) == 1);
        step();
        bus.snt = 1'b0;
        check("rnd_idle_done", bus.req_done, 0);
      end
      mask = N_REQ'($urandom_range(1, (1 << N_REQ) - 1));
      rand_words();
      run_xfer(mask, $urandom_range(0, 4), model_grant(mask), ($urandom_range(0, 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/bridge_tx_arb.md
# bridge_tx_arb

Round-robin arbiter that shares one transmit channel of the two-flop, four-phase clock-domain bridge between several Wishbone-side requesters. It runs in the transmit clock domain, sits directly in front of the `tx` synchronizer, and sequences exactly one transfer at a time. For each transfer it presents a stable `sdata` word, issues a one-cycle `vi` launch, waits for the `snt` completion pulse, and then returns a one-cycle done strobe to the granted requester.

## Interface
- `DATA_W`, 32: word width; equals `DATA_MSB+1` of the attached `tx`.
- `N_REQ`, 4: number of requesters, 2..8.
- `PTR_W`, 3: grant index width; must satisfy 2^PTR_W >= N_REQ.

- `clk` in 1: transmit-domain clock; same clock as the attached `tx`.
- `reset` in 1: synchronous, active-high reset, sampled on the rising edge of `clk`.
- `req_valid` in N_REQ: bit i set means requester i has a word pending; it is held until `req_done[i]`.
- `req_data` in N_REQ*DATA_W: requester i's word occupies bits [i*DATA_W +: DATA_W].
- `req_done` out N_REQ: one-cycle strobe to the granted requester when `tx` reports the word sent.
- `sdata` out DATA_W: word to the `tx` `sdata` input; registered and stable from grant until the done strobe.
- `vi` out 1: one-cycle launch pulse to the `tx` `vi` input.
- `snt` in 1: one-cycle sent pulse from `tx`.
- `busy` out 1: high in every state except IDLE.
- `grant_id` out PTR_W: index of the current or last granted requester.
- `xfer_cnt` out 16: number of completed transfers; wraps around.

## Operation
- State machine with states IDLE, ISSUE, WAIT, DONE, all registered.
- IDLE:
  - If any `req_valid` bit is set, select the first set bit, searching upward from `ptr` and wrapping modulo N_REQ.
  - Load `grant_id` with the selected index and `sdata` with that requester's `req_data` slice, then go to ISSUE.
  - If no bit is set, stay in IDLE.
- ISSUE: `vi`=1 for this single cycle; go to WAIT unconditionally.
- WAIT: `vi`=0.
  - On `snt`=1, go to DONE.
  - Otherwise stay in WAIT; there is no timeout.
- DONE:
  - `req_done[grant_id]`=1 for this single cycle.
  - `ptr` <= (`grant_id`+1) mod N_REQ, computed without relying on power-of-two wrap.
  - `xfer_cnt` increments.
  - Go to IDLE.
- `vi`, `req_done` and `busy` are registered, decoded from the next state.
- `snt` outside WAIT (IDLE, ISSUE or DONE) is ignored: no state change and no count.
- If `req_valid[grant_id]` drops after the grant, the transfer still completes and the done strobe is still issued. `sdata` is never re-sampled during a transfer.
- A requester must deassert `req_valid` in the cycle after `req_done`; if it stays high, it is treated as a new request.
- `xfer_cnt` wraps from 16'hFFFF to 16'h0000.
- Reset values: state=IDLE, `ptr`=0, `grant_id`=0, `sdata`=0, `vi`=0, `req_done`=0, `busy`=0, `xfer_cnt`=0.
- Reset asserted mid-transfer (ISSUE, WAIT or DONE) aborts the transfer without a done strobe. Any `snt` arriving after reset is released is ignored unless the arbiter is in WAIT.

## Timing
- Cycle 0: `req_valid` first sampled high in IDLE.
- Cycle 1: `vi`=1, `busy`=1, `sdata` valid.
- Cycle 2 onward: WAIT.
- `snt` high in cycle k (k >= 2): `req_done` high in cycle k+1, IDLE in cycle k+2.
- Minimum spacing between `vi` pulses: 4 cycles plus the `tx` round-trip time.
- Back-to-back: a new grant can be made in the IDLE cycle k+2, giving the next `vi` in cycle k+3.
- Fairness: with all requesters continuously active, each is granted once per N_REQ transfers.

## Configuration
- `BRIDGE_ARB_PRIO0_EN` defined:
  - Requester 0 wins whenever its `req_valid` bit is set in IDLE.
  - The remaining requesters are arbitrated round-robin as above.
  - `ptr` is not advanced by grants to requester 0.
- `BRIDGE_ARB_PRIO0_EN` undefined: pure round-robin over all N_REQ requesters.

## Test plan
- Single request, no contention: `req_valid`=4'b0100 with data 32'hDEADBEEF, `snt` returned 6 cycles after `vi` -> `vi` in cycle 1, `sdata`=32'hDEADBEEF held through DONE, `req_done`=4'b0100 in cycle 8, `xfer_cnt`=1.
- All four requesters continuously valid -> grant order 0,1,2,3,0, with exactly one `req_done` per grant.
  - With `BRIDGE_ARB_PRIO0_EN` and requester 0 re-requesting immediately -> order 0,0,0 while requester 0 stays valid.
- Spurious `snt` in IDLE and in ISSUE -> no state change, no `req_done`, `xfer_cnt` unchanged.
- Reset pulse for one cycle while in WAIT -> all outputs 0 in the next cycle. A late `snt` afterwards gives no `req_done`.
- Requester drops `req_valid` during WAIT -> transfer completes and `req_done` still pulses for that requester.
- Preload 65535 completed transfers, then perform one more -> `xfer_cnt`=16'h0000.
